apb_master_seq: RTL and testbench
=================================

# apb_master_seq

APB-side sequencer of the AHB→APB bridge. It drains the control FIFO, and the write-data FIFO for writes, that the AHB slave front end fills. Each entry becomes exactly one APB4 transfer through SETUP and ACCESS phases. Read data is pushed into the APB→AHB read-data FIFO. The block runs on the bridge's single clock and keeps at most one APB transfer outstanding.

## Interface
- haddrWidth, 8, address width; equal to PADDR width.
- hdataWidth, 32, data width; fixed at 32 for the PSTRB rules.
- CTRL_W, 1+2+3+3+haddrWidth, ctrl entry width, packed {HWRITE, HTRANS[1:0], HBURST[2:0], HSIZE[2:0], HADDR}.

Ports:
- HCLK  in  1  bridge clock; all logic on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- ctrl_empty  in  1  control FIFO empty.
- ctrl_rdata  in  CTRL_W  control FIFO head (first-word-fall-through, valid when !ctrl_empty).
- ctrl_ren  out  1  pop control FIFO head.
- ahb_data_empty  in  1  write-data FIFO empty.
- ahb_data_rdata  in  hdataWidth  write-data FIFO head (FWFT).
- ahb_data_ren  out  1  pop write-data FIFO head.
- apb_data_full  in  1  read-data FIFO full.
- apb_data_wen  out  1  push read data.
- apb_data_wdata  out  hdataWidth  read-data payload.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  haddrWidth  APB address.
- PWDATA  out  hdataWidth  APB write data.
- PSTRB  out  hdataWidth/8  write byte strobes.
- PRDATA  in  hdataWidth  APB read data.
- PREADY, PSLVERR  in  1 each  APB completion and error.
- busy  out  1  high in SETUP or ACCESS.
- slverr_cnt  out  8  saturating count of PSLVERR completions.

## Operation
- States: IDLE, SETUP, ACCESS.
- Issue condition (issue_ok): !ctrl_empty, plus:
  - write head (ctrl_rdata MSB = 1): also !ahb_data_empty;
  - read head: also !apb_data_full.
- Read-data space is reserved at issue. Only this block pushes to the read-data FIFO and only one transfer is outstanding, so the push at completion never overflows.
- IDLE: if issue_ok, pulse ctrl_ren (and ahb_data_ren for writes) in the same cycle, register the transfer fields, and go to SETUP. Otherwise stay in IDLE with no pops.
- Registered fields, held stable through SETUP and ACCESS:
  - PADDR = HADDR, PWRITE = HWRITE.
  - PWDATA = ahb_data_rdata for writes; for reads it holds its previous value.
- PSTRB for writes, from HSIZE and HADDR[1:0]:
  - byte (000): 4'b0001 << HADDR[1:0];
  - half (001): 4'b0011 << {HADDR[1],1'b0};
  - any larger size: 4'b1111.
  - Reads: PSTRB = 0.
- HTRANS and HBURST are carried in the entry but ignored. Every entry is one independent APB transfer.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1; wait while PREADY=0. When PREADY=1:
  - read: pulse apb_data_wen with apb_data_wdata = PRDATA. The push happens even when PSLVERR=1.
  - PSLVERR=1: slverr_cnt increments and saturates at 255.
  - issue_ok true: pop the next entry in the same cycle and go straight to SETUP. PSEL stays 1 and PENABLE drops to 0.
  - issue_ok false: go to IDLE with PSEL=0, PENABLE=0.
- FIFO enables (ctrl_ren, ahb_data_ren, apb_data_wen) are single-cycle pulses and are never asserted in SETUP.
- busy = (state != IDLE).

## Timing
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state IDLE;
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB all 0;
  - ctrl_ren, ahb_data_ren, apb_data_wen, apb_data_wdata all 0;
  - busy 0, slverr_cnt 0.
  - A transfer aborted by reset is not replayed, and its entry is not restored.
- All outputs are registered except the FIFO enables and apb_data_wdata, which are combinational from state, FIFO status and PREADY.
- Issue latency: issue_ok sampled true in IDLE at edge N → pop at N, SETUP in cycle N+1, ACCESS in cycle N+2.
- Minimum transfer: 2 cycles (PREADY=1 in the first ACCESS cycle). Back-to-back throughput: one transfer per 2 cycles, with no IDLE gap.
- Each PREADY=0 cycle in ACCESS adds one cycle. PREADY and PSLVERR are ignored outside ACCESS.
- Write whose data FIFO is empty: the write waits in IDLE, and ctrl_ren is not asserted until data is present. This holds even if later read entries would be eligible: order is strict FIFO.
- Read with apb_data_full=1: it waits in IDLE until full deasserts.

## Test plan
- Single write: ctrl entry {1, NSEQ, SINGLE, word, 0x40}, data 0xDEADBEEF → ctrl_ren and ahb_data_ren both pulse at edge N; SETUP at N+1 with PADDR=0x40, PWRITE=1, PSTRB=4'hF; ACCESS at N+2; PREADY=1 → IDLE, PSEL=0.
- Read with 3 wait states: entry {0, …, 0x10}, PRDATA=0x12345678 → ACCESS lasts 4 cycles; apb_data_wen is a single pulse with wdata=0x12345678; PSTRB=0.
- Byte and half strobes: byte write at 0x43 → PSTRB=4'b1000; half write at 0x42 → PSTRB=4'b1100.
- Back-to-back: four queued writes, PREADY=1 throughout → PSEL stays 1 for 8 cycles, PENABLE toggles 0,1,0,1,…, and there are four ctrl_ren pulses.
- Backpressure and ordering:
  - write entry with ahb_data_empty=1 for 5 cycles → no pops, PSEL=0; data arrives → issue next cycle;
  - read with apb_data_full=1 → no issue until full clears.
- Error and reset: 300 PSLVERR completions → slverr_cnt=255. HRESETn asserted in ACCESS → PSEL=0, PENABLE=0, busy=0 immediately.

Source files
------------

// File: rtl/apb_master_seq.sv
// APB-side sequencer of the AHB->APB bridge: turns each control-FIFO entry into one
// APB4 SETUP/ACCESS transfer and pushes read data into the APB->AHB read-data FIFO.
module apb_master_seq #(
  parameter int haddrWidth = 8,
  parameter int hdataWidth = 32,
  parameter int CTRL_W     = 1 + 2 + 3 + 3 + haddrWidth
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    ctrl_empty,
  input  logic [CTRL_W-1:0]       ctrl_rdata,
  output logic                    ctrl_ren,
  input  logic                    ahb_data_empty,
  input  logic [hdataWidth-1:0]   ahb_data_rdata,
  output logic                    ahb_data_ren,
  input  logic                    apb_data_full,
  output logic                    apb_data_wen,
  output logic [hdataWidth-1:0]   apb_data_wdata,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [haddrWidth-1:0]   PADDR,
  output logic [hdataWidth-1:0]   PWDATA,
  output logic [hdataWidth/8-1:0] PSTRB,
  input  logic [hdataWidth-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  output logic                    busy,
  output logic [7:0]              slverr_cnt
);

  localparam int STRB_W = hdataWidth / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [haddrWidth-1:0]   paddr_q, paddr_d;
  logic [hdataWidth-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic                    busy_q, busy_d;
  logic [7:0]              slverr_q, slverr_d;

  logic                    head_write;
  logic [2:0]              head_size;
  logic [haddrWidth-1:0]   head_addr;
  logic [STRB_W-1:0]       head_strb;
  logic                    issue_ok;
  logic                    issue;
  logic                    done;
  logic                    unused_fields;

  assign head_write = ctrl_rdata[CTRL_W-1];
  assign head_size  = ctrl_rdata[haddrWidth+2:haddrWidth];
  assign head_addr  = ctrl_rdata[haddrWidth-1:0];

  // HTRANS and HBURST travel with the entry but every entry is a single APB transfer.
  assign unused_fields = ^ctrl_rdata[CTRL_W-2 -: 5];

  // Read space is reserved at issue time, so a completing read can never overflow.
  assign issue_ok = !ctrl_empty && (head_write ? !ahb_data_empty : !apb_data_full);
  assign done     = (state_q == ACCESS) && PREADY;

  always_comb begin
    head_strb = '0;
    if (head_write) begin
      unique case (head_size)
        3'b000:  head_strb = STRB_W'(4'b0001 << head_addr[1:0]);
        3'b001:  head_strb = STRB_W'(4'b0011 << {head_addr[1], 1'b0});
        default: head_strb = '1;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue_ok) begin
          issue   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          if (issue_ok) begin
            issue   = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
    busy_d    = (state_d != IDLE);
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    slverr_d  = slverr_q;
    if (issue) begin
      pwrite_d = head_write;
      paddr_d  = head_addr;
      pstrb_d  = head_strb;
      if (head_write) pwdata_d = ahb_data_rdata;
    end
    if (done && PSLVERR && (slverr_q != 8'hFF)) slverr_d = slverr_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      busy_q    <= 1'b0;
      slverr_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      busy_q    <= busy_d;
      slverr_q  <= slverr_d;
    end
  end

  assign ctrl_ren       = issue;
  assign ahb_data_ren   = issue && head_write;
  assign apb_data_wen   = done && !pwrite_q;
  assign apb_data_wdata = apb_data_wen ? PRDATA : '0;

  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign busy       = busy_q;
  assign slverr_cnt = slverr_q;

endmodule

// File: tb/tb_apb_master_seq.sv
// Self-checking bench for apb_master_seq: directed scenarios plus random traffic, all
// checked by a transfer-level model that tracks FIFO contents and APB phase order.
module tb_apb_master_seq;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 1 + 2 + 3 + 3 + AW;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic            ctrl_empty, ctrl_ren;
  logic [CW-1:0]   ctrl_rdata;
  logic            ahb_data_empty, ahb_data_ren;
  logic [DW-1:0]   ahb_data_rdata;
  logic            apb_data_full, apb_data_wen;
  logic [DW-1:0]   apb_data_wdata;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA, PRDATA;
  logic [DW/8-1:0] PSTRB;
  logic            PREADY, PSLVERR, busy;
  logic [7:0]      slverr_cnt;

  apb_master_seq #(.haddrWidth(AW), .hdataWidth(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .ctrl_empty(ctrl_empty), .ctrl_rdata(ctrl_rdata), .ctrl_ren(ctrl_ren),
    .ahb_data_empty(ahb_data_empty), .ahb_data_rdata(ahb_data_rdata), .ahb_data_ren(ahb_data_ren),
    .apb_data_full(apb_data_full), .apb_data_wen(apb_data_wen), .apb_data_wdata(apb_data_wdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .slverr_cnt(slverr_cnt)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bench-side FIFOs feeding the DUT.
  logic [CW-1:0] ctrl_q[$];
  logic [DW-1:0] wd_q[$];
  int            total_pushed = 0;

  // Model state owned by the monitor.
  bit            pop_c = 1'b0, pop_d = 1'b0;
  logic [1:0]    exp_ph = 2'b00;
  logic [AW-1:0] cur_addr = '0;
  logic          cur_wr = 1'b0;
  logic [3:0]    cur_strb = '0;
  logic [DW-1:0] cur_wd = '0, last_wd = '0;
  int            err_n = 0;
  int            n_done = 0;
  logic          m_head_wr, m_head_ok, m_completing, m_exp_pop;

  function automatic logic [3:0] exp_strb(input logic [CW-1:0] e);
    logic [1:0] lane;
    lane = e[1:0];
    if (!e[CW-1]) return 4'h0;
    case (e[AW+2:AW])
      3'd0:    return 4'h1 << lane;
      3'd1:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  task automatic update_ports();
    ctrl_empty     = (ctrl_q.size() == 0);
    ctrl_rdata     = ctrl_empty ? '0 : ctrl_q[0];
    ahb_data_empty = (wd_q.size() == 0);
    ahb_data_rdata = ahb_data_empty ? '0 : wd_q[0];
  endtask

  // Advance to just after the next rising edge and retire whatever the DUT popped there.
  task automatic tick();
    @(posedge HCLK);
    #1;
    if (HRESETn) begin
      if (pop_c && ctrl_q.size() != 0) void'(ctrl_q.pop_front());
      if (pop_d && wd_q.size() != 0) void'(wd_q.pop_front());
    end
    update_ports();
  endtask

  task automatic push_ctrl(input logic w, input logic [1:0] tr, input logic [2:0] bu,
                           input logic [2:0] sz, input logic [AW-1:0] a);
    ctrl_q.push_back({w, tr, bu, sz, a});
    total_pushed++;
  endtask

  task automatic push_data(input logic [DW-1:0] d);
    wd_q.push_back(d);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    apb_data_full = 1'b0;
    while ((ctrl_q.size() != 0 || PSEL) && k < limit) begin
      tick();
      k++;
    end
    check("drain_done", (ctrl_q.size() == 0) && !PSEL, 1);
  endtask

  // Monitor: every cycle, compares the DUT against the transfer-level rules.
  initial forever begin
    @(negedge HCLK);
    if (!HRESETn) begin
      pop_c   = 1'b0;
      pop_d   = 1'b0;
      exp_ph  = 2'b00;
      last_wd = '0;
      err_n   = 0;
    end else begin
      m_head_wr    = (ctrl_q.size() != 0) && ctrl_q[0][CW-1];
      m_head_ok    = (ctrl_q.size() != 0) && (m_head_wr ? (wd_q.size() != 0) : !apb_data_full);
      m_completing = (exp_ph == 2'b11) && PREADY;
      m_exp_pop    = m_head_ok && ((exp_ph == 2'b00) || m_completing);

      check("apb_phase", {PSEL, PENABLE}, exp_ph);
      check("busy", busy, exp_ph != 2'b00);
      check("slverr_cnt", slverr_cnt, (err_n > 255) ? 255 : err_n);
      check("ctrl_ren", ctrl_ren, m_exp_pop);
      check("ahb_data_ren", ahb_data_ren, m_exp_pop && m_head_wr);
      check("apb_data_wen", apb_data_wen, m_completing && !cur_wr);

      if (exp_ph == 2'b10 || m_completing) begin
        check("paddr", PADDR, cur_addr);
        check("pwrite", PWRITE, cur_wr);
        check("pstrb", PSTRB, cur_strb);
        check("pwdata", PWDATA, cur_wd);
      end
      if (m_completing) begin
        if (!cur_wr) check("rd_push_data", apb_data_wdata, PRDATA);
        if (PSLVERR) err_n++;
        n_done++;
      end

      pop_c = ctrl_ren && (ctrl_q.size() != 0);
      pop_d = ahb_data_ren && (wd_q.size() != 0);
      if (pop_c) begin
        cur_addr = ctrl_q[0][AW-1:0];
        cur_wr   = ctrl_q[0][CW-1];
        cur_strb = exp_strb(ctrl_q[0]);
        cur_wd   = cur_wr ? ((wd_q.size() != 0) ? wd_q[0] : '0) : last_wd;
        if (cur_wr) last_wd = cur_wd;
      end

      if (ctrl_ren)                         exp_ph = 2'b10;
      else if (exp_ph == 2'b10)             exp_ph = 2'b11;
      else if (exp_ph == 2'b11 && !PREADY)  exp_ph = 2'b11;
      else                                  exp_ph = 2'b00;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          acc, wen_n, ns, psel_n, ren_n, pen_bad, run, max_run, k;
  int          wr_pushed, data_pushed;
  logic        pen_exp, w;
  logic [3:0]  strb_seen[2];

  initial begin
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; apb_data_full = 1'b0;
    update_ports();

    // Reset values while reset is held.
    #23;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pstrb", PSTRB, 0);
    check("rst_busy", busy, 0);
    check("rst_slverr", slverr_cnt, 0);
    check("rst_wen", apb_data_wen, 0);
    check("rst_wdata", apb_data_wdata, 0);
    tick();
    HRESETn = 1'b1;

    // Single word write to 0x40.
    PREADY = 1'b1;
    push_ctrl(1'b1, 2'b10, 3'b000, 3'b010, 8'h40);
    push_data(32'hDEADBEEF);
    update_ports();
    @(negedge HCLK);
    check("t1_ctrl_ren", ctrl_ren, 1);
    check("t1_data_ren", ahb_data_ren, 1);
    tick(); @(negedge HCLK);
    check("t1_setup", {PSEL, PENABLE}, 2'b10);
    check("t1_paddr", PADDR, 8'h40);
    check("t1_pwrite", PWRITE, 1);
    check("t1_pstrb", PSTRB, 4'hF);
    check("t1_pwdata", PWDATA, 32'hDEADBEEF);
    tick(); @(negedge HCLK);
    check("t1_access", {PSEL, PENABLE}, 2'b11);
    tick(); @(negedge HCLK);
    check("t1_idle", PSEL, 0);

    // Read from 0x10 with three wait states.
    tick();
    PREADY = 1'b0;
    PRDATA = 32'h12345678;
    push_ctrl(1'b0, 2'b10, 3'b000, 3'b010, 8'h10);
    update_ports();
    @(negedge HCLK);
    check("t2_ctrl_ren", ctrl_ren, 1);
    tick(); @(negedge HCLK);
    check("t2_pstrb", PSTRB, 0);
    acc = 0; wen_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      PREADY = (acc == 3);
      @(negedge HCLK);
      if (PSEL && PENABLE) begin
        acc++;
        if (apb_data_wen) begin
          wen_n++;
          check("t2_rdata", apb_data_wdata, 32'h12345678);
        end
      end
    end
    check("t2_access_cycles", acc, 4);
    check("t2_wen_pulses", wen_n, 1);

    // Byte write at 0x43 and half write at 0x42.
    tick();
    PREADY = 1'b1;
    push_ctrl(1'b1, 2'b10, 3'b000, 3'b000, 8'h43); push_data(32'h0000_00AA);
    push_ctrl(1'b1, 2'b10, 3'b000, 3'b001, 8'h42); push_data(32'h0000_BB00);
    update_ports();
    ns = 0;
    strb_seen[0] = '0; strb_seen[1] = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      if (PSEL && !PENABLE && ns < 2) begin
        strb_seen[ns] = PSTRB;
        ns++;
      end
      tick();
    end
    check("t3_byte_strb", strb_seen[0], 4'b1000);
    check("t3_half_strb", strb_seen[1], 4'b1100);

    // Four back-to-back writes with PREADY held high.
    for (int i = 0; i < 4; i++) begin
      push_ctrl(1'b1, 2'b11, 3'b011, 3'b010, 8'(8'h50 + 4 * i));
      push_data($urandom);
    end
    update_ports();
    psel_n = 0; ren_n = 0; pen_bad = 0; pen_exp = 1'b0; run = 0; max_run = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge HCLK);
      ren_n += int'(ctrl_ren);
      if (PSEL) begin
        psel_n++;
        run++;
        if (PENABLE !== pen_exp) pen_bad++;
        pen_exp = !pen_exp;
      end else begin
        run = 0;
      end
      if (run > max_run) max_run = run;
      tick();
    end
    check("t4_psel_cycles", psel_n, 8);
    check("t4_psel_run", max_run, 8);
    check("t4_ren_pulses", ren_n, 4);
    check("t4_penable_toggle", pen_bad, 0);

    // A write without data blocks itself and the read queued behind it.
    push_ctrl(1'b1, 2'b10, 3'b000, 3'b010, 8'h60);
    push_ctrl(1'b0, 2'b10, 3'b000, 3'b010, 8'h64);
    update_ports();
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      check("t5_no_pop", ctrl_ren, 0);
      check("t5_no_psel", PSEL, 0);
      tick();
    end
    push_data(32'hCAFEF00D);
    update_ports();
    @(negedge HCLK);
    check("t5_issue_on_data", ctrl_ren, 1);
    drain(20);

    // A read waits while the read-data FIFO is full.
    apb_data_full = 1'b1;
    push_ctrl(1'b0, 2'b10, 3'b000, 3'b010, 8'h70);
    update_ports();
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check("t6_full_no_pop", ctrl_ren, 0);
      tick();
    end
    apb_data_full = 1'b0;
    @(negedge HCLK);
    check("t6_issue_on_space", ctrl_ren, 1);
    drain(20);

    // 300 erroring reads saturate the error counter.
    PREADY = 1'b1; PSLVERR = 1'b1;
    for (int i = 0; i < 300; i++) push_ctrl(1'b0, 2'b10, 3'b000, 3'b010, 8'($urandom));
    update_ports();
    k = 0;
    while (ctrl_q.size() != 0 && k < 800) begin
      PRDATA = $urandom;
      tick();
      k++;
    end
    drain(10);
    check("t7_slverr_sat", slverr_cnt, 255);

    // Random traffic.
    wr_pushed = 0; data_pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (ctrl_q.size() < 4 && $urandom_range(0, 2) == 0) begin
        w = 1'($urandom_range(0, 1));
        push_ctrl(w, 2'($urandom), 3'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
        if (w) wr_pushed++;
      end
      if (data_pushed < wr_pushed && $urandom_range(0, 1) == 1) begin
        push_data($urandom);
        data_pushed++;
      end
      if ($urandom_range(0, 7) == 0) apb_data_full = !apb_data_full;
      PREADY  = ($urandom_range(0, 3) != 0);
      PSLVERR = ($urandom_range(0, 5) == 0);
      PRDATA  = $urandom;
      update_ports();
    end
    while (data_pushed < wr_pushed) begin
      push_data($urandom);
      data_pushed++;
    end
    update_ports();
    drain(400);
    check("all_completed", n_done, total_pushed);

    // Reset asserted during ACCESS.
    tick();
    PREADY = 1'b0;
    push_ctrl(1'b0, 2'b10, 3'b000, 3'b010, 8'h20);
    update_ports();
    k = 0;
    while (!(PSEL && PENABLE) && k < 10) begin
      tick();
      k++;
    end
    check("t8_reached_access", PSEL && PENABLE, 1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("t8_rst_psel", PSEL, 0);
    check("t8_rst_penable", PENABLE, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_slverr", slverr_cnt, 0);
    tick();
    HRESETn = 1'b1;
    tick(); tick();
    check("t8_no_replay", PSEL, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
